// File: rtl/display_7seg_pkg.sv
// Shared constants and nibble-to-segment decode for the scanned 7-segment display.
// Segment patterns are packed a..g from MSB to LSB and are active-low.
package display_7seg_pkg;

   localparam logic [6:0] SEG_APAGADO = 7'b1111111;
   localparam logic [6:0] SEG_TRACO   = 7'b1111110;

   localparam logic [6:0] SEG_TABELA [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   // A nibble with X/Z bits matches no entry and decodes to a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
      logic [6:0] seg;
      seg = SEG_TRACO;
      for (int i = 0; i < 16; i++) begin
         if (nibble == 4'(i)) seg = SEG_TABELA[i];
      end
      return seg;
   endfunction

endpackage

// File: rtl/display_7seg_varredura_if.sv
// Connects the processor output register to the scanned 7-segment display driver.
// The master drives the value and strobes. The slave drives the segment and anode pins.
interface display_7seg_varredura_if #(
   parameter int unsigned DIGITOS = 4
);
   logic [4*DIGITOS-1:0] valor;
   logic                 carregar;
   logic                 apagar;
   logic [0:6]           saida;
   logic [DIGITOS-1:0]   anodos;
   logic                 varredura;

   modport master (
      output valor, carregar, apagar,
      input  saida, anodos, varredura
   );

   modport slave (
      input  valor, carregar, apagar,
      output saida, anodos, varredura
   );
endinterface

// File: rtl/display_7seg_varredura_decodificador.sv
// Combinational nibble-to-segment decoder shared by all scanned digits.
module decodificador_7seg
   import display_7seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   assign seg = seg_decode(nibble);
endmodule

// File: rtl/display_7seg_varredura.sv
// Time-multiplexed common-anode 7-segment driver: buffers a hex word and scans one digit per tick.
// Define DISPLAY_ZERO_ESQ_EN to blank leading zero digits (digit 0 is always shown).
module display_7seg_varredura
   import display_7seg_pkg::*;
#(
   parameter int unsigned DIGITOS       = 4,
   parameter int unsigned DIV_VARREDURA = 50000
) (
   input  logic                     clock,
   input  logic                     reset,
   display_7seg_varredura_if.slave  bus
);
   localparam int unsigned CW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
   localparam int unsigned IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

   logic [4*DIGITOS-1:0] buffer;
   logic [CW-1:0]        contador;
   logic [IW-1:0]        idx;
   logic                 tick;
   logic [3:0]           digitos_buf [DIGITOS];
   logic [3:0]           nibble;
   logic [6:0]           seg;
   logic                 suprimir;

   assign tick = (contador == CW'(DIV_VARREDURA - 1));

   always_comb begin
      for (int i = 0; i < int'(DIGITOS); i++) digitos_buf[i] = buffer[4*i +: 4];
   end

   assign nibble = digitos_buf[idx];

   decodificador_7seg u_dec (
      .nibble (nibble),
      .seg    (seg)
   );

`ifdef DISPLAY_ZERO_ESQ_EN
   logic [DIGITOS-1:0] zero_acima;

   // zero_acima[i]: digit i and every digit above it hold nibble 0.
   always_comb begin
      logic acc;
      acc        = 1'b1;
      zero_acima = '0;
      for (int i = int'(DIGITOS) - 1; i >= 0; i--) begin
         acc           = acc & (digitos_buf[i] == 4'h0);
         zero_acima[i] = acc;
      end
   end

   assign suprimir = (idx != '0) && zero_acima[idx];
`else
   assign suprimir = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         buffer        <= '0;
         contador      <= '0;
         idx           <= '0;
         bus.saida     <= SEG_APAGADO;
         bus.anodos    <= '1;
         bus.varredura <= 1'b0;
      end else begin
         if (bus.carregar) buffer <= bus.valor;
         bus.varredura <= tick;
         contador      <= tick ? '0 : contador + CW'(1);
         // The tick decodes the buffer as it stood before this edge's load.
         if (tick) begin
            if (bus.apagar || suprimir) begin
               bus.saida  <= SEG_APAGADO;
               bus.anodos <= '1;
            end else begin
               bus.saida  <= seg;
               bus.anodos <= ~(DIGITOS'(1) << idx);
            end
            idx <= (idx == IW'(DIGITOS - 1)) ? '0 : idx + IW'(1);
         end
      end
   end

endmodule
